// File: rtl/sipo_pkg.sv
// Shared types and constants for the serial-in/parallel-out frame receiver.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package sipo_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // Holding register occupancy: EMPTY means out_valid=0, FULL means out_valid=1.
  typedef enum logic {
    HOLD_EMPTY = 1'b0,
    HOLD_FULL  = 1'b1
  } hold_state_t;

  // Counter width able to hold 0..width, so bit counters never truncate.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/sipo_shift_core.sv
// Shift register plus bit counter; emits the assembled word with a one-edge done pulse.
// Latency: word/done are combinational on the edge that samples the last bit.
// Backpressure: none; a frame completes whenever WIDTH bits are loaded, flush cancels it.
module sipo_shift_core
  import sipo_pkg::*;
#(
  parameter int  WIDTH     = DEFAULT_WIDTH,
  parameter bit  MSB_FIRST = 1'b1,
  localparam int CW        = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             data_in,
  input  logic             flush,
  output logic [WIDTH-1:0] word,
  output logic             done,
  output logic [CW-1:0]    bit_cnt
);

  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_shift;
  logic             last_bit;

  // Next shift value; the completed word includes the bit sampled on this edge.
  always_comb begin
    sr_shift = '0;
    if (MSB_FIRST) sr_shift = {sr[WIDTH-2:0], data_in};
    else           sr_shift = {data_in, sr[WIDTH-1:1]};
  end

  assign last_bit = (bit_cnt == CW'(WIDTH - 1));
  assign done     = load && !flush && last_bit;
  assign word     = sr_shift;

  // Shift and count; flush wins over load, the counter wraps on the last bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr      <= '0;
      bit_cnt <= '0;
    end else if (flush) begin
      sr      <= '0;
      bit_cnt <= '0;
    end else if (load) begin
      sr      <= sr_shift;
      bit_cnt <= last_bit ? '0 : bit_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/sipo_frame_rx.sv
// Serial frame receiver: assembles WIDTH bits and presents each word in a one-entry holding register.
// Latency: data_out/out_valid update on the edge that samples the last bit of a frame.
// Backpressure: out_ready drains the holder; a word completing while the holder stays full is dropped and sets sticky overrun.
module sipo_frame_rx
  import sipo_pkg::*;
#(
  parameter int  WIDTH     = DEFAULT_WIDTH,
  parameter bit  MSB_FIRST = 1'b1,
  localparam int CW        = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             data_in,
  input  logic             flush,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun,
  output logic [CW-1:0]    bit_cnt
);

  logic [WIDTH-1:0] word;
  logic             done;
  hold_state_t      state;
  hold_state_t      state_next;
  logic [WIDTH-1:0] data_next;
  logic             overrun_next;

  sipo_shift_core #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .data_in (data_in),
    .flush   (flush),
    .word    (word),
    .done    (done),
    .bit_cnt (bit_cnt)
  );

  assign out_valid = (state == HOLD_FULL);

  // Holding register transitions; a same-edge consume lets a new word replace the old one.
  always_comb begin
    state_next   = state;
    data_next    = data_out;
    overrun_next = overrun;
    case (state)
      HOLD_EMPTY: begin
        if (done) begin
          state_next = HOLD_FULL;
          data_next  = word;
        end
      end
      HOLD_FULL: begin
        if (done && out_ready) begin
          data_next = word;
        end else if (done) begin
          overrun_next = 1'b1;
        end else if (out_ready) begin
          state_next = HOLD_EMPTY;
        end
      end
      default: state_next = HOLD_EMPTY;
    endcase
  end

  // Holding register, occupancy and sticky overrun flag; only rst clears overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= HOLD_EMPTY;
      data_out <= '0;
      overrun  <= 1'b0;
    end else begin
      state    <= state_next;
      data_out <= data_next;
      overrun  <= overrun_next;
    end
  end

endmodule

// File: tb/tb_sipo_frame_rx.sv
// Bench for sipo_frame_rx: MSB-first and LSB-first instances share one stimulus stream.
// Latency: expected words are queued when a frame is driven and popped on each handshake.
// Backpressure: out_ready is driven per test to exercise drain, overrun and same-edge replace.
module tb_sipo_frame_rx;

  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          load;
  logic          data_in;
  logic          flush;
  logic          out_ready;
  logic [W-1:0]  m_data, l_data;
  logic          m_valid, l_valid;
  logic          m_ovr, l_ovr;
  logic [CW-1:0] m_cnt, l_cnt;

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] q_m[$];
  logic [W-1:0] q_l[$];
  logic [W-1:0] exp_m, exp_l;

  always #5 clk = ~clk;

  sipo_frame_rx #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .load(load), .data_in(data_in), .flush(flush),
    .data_out(m_data), .out_valid(m_valid), .out_ready(out_ready),
    .overrun(m_ovr), .bit_cnt(m_cnt)
  );

  sipo_frame_rx #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .load(load), .data_in(data_in), .flush(flush),
    .data_out(l_data), .out_valid(l_valid), .out_ready(out_ready),
    .overrun(l_ovr), .bit_cnt(l_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] rev(input logic [W-1:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = v[W-1-i];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // The first bit sent is v[W-1]; the MSB-first unit returns v, the LSB-first unit its reverse.
  task automatic push(input logic [W-1:0] v);
    q_m.push_back(v);
    q_l.push_back(rev(v));
  endtask

  task automatic send_frame(input logic [W-1:0] v, input int gap_a, input int gap_b,
                            input int gap_len, input logic rdy_last);
    for (int i = 0; i < W; i++) begin
      load      = 1'b1;
      data_in   = v[W-1-i];
      out_ready = (i == W - 1) ? rdy_last : 1'b0;
      tick();
      if ((i + 1 == gap_a) || (i + 1 == gap_b)) begin
        load = 1'b0;
        for (int g = 0; g < gap_len; g++) begin
          tick();
          chk("gap_bit_cnt", 32'(m_cnt), 32'(i + 1));
        end
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic consume();
    load      = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  // Scoreboard: every accepted word (valid && ready before an edge) must match the queue head.
  always @(negedge clk) begin
    if (!rst && out_ready) begin
      if (m_valid) begin
        chk("m_word_expected", 32'(q_m.size() != 0), 32'd1);
        if (q_m.size() != 0) begin
          exp_m = q_m.pop_front();
          chk("m_word", 32'(m_data), 32'(exp_m));
        end
      end
      if (l_valid) begin
        chk("l_word_expected", 32'(q_l.size() != 0), 32'd1);
        if (q_l.size() != 0) begin
          exp_l = q_l.pop_front();
          chk("l_word", 32'(l_data), 32'(exp_l));
        end
      end
    end
  end

  initial begin
    rst = 1'b1; load = 1'b0; data_in = 1'b0; flush = 1'b0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_data", 32'(m_data), 32'h0);
    chk("rst_valid", 32'(m_valid), 32'h0);
    chk("rst_overrun", 32'(m_ovr), 32'h0);
    chk("rst_bit_cnt", 32'(m_cnt), 32'h0);
    chk("rst_l_valid", 32'(l_valid), 32'h0);

    // Basic frame, both shift orders
    push(8'hF0);
    send_frame(8'hF0, 0, 0, 0, 1'b0);
    chk("t1_valid", 32'(m_valid), 32'h1);
    chk("t1_m_data", 32'(m_data), 32'hF0);
    chk("t1_l_data", 32'(l_data), 32'h0F);
    chk("t1_bit_cnt", 32'(m_cnt), 32'h0);
    consume();
    chk("t1_drained", 32'(m_valid), 32'h0);

    // Alternating pattern
    push(8'hAA);
    send_frame(8'hAA, 0, 0, 0, 1'b0);
    chk("t2_m_data", 32'(m_data), 32'hAA);
    chk("t2_l_data", 32'(l_data), 32'h55);
    consume();

    // Gapped load: bit_cnt holds during gaps
    push(8'hAA);
    send_frame(8'hAA, 2, 5, 3, 1'b0);
    chk("t3_m_data", 32'(m_data), 32'hAA);
    chk("t3_valid", 32'(m_valid), 32'h1);
    consume();

    // Overrun: second word dropped while holder stays full
    push(8'hF0);
    send_frame(8'hF0, 0, 0, 0, 1'b0);
    send_frame(8'hFF, 0, 0, 0, 1'b0);
    chk("t4_m_data_kept", 32'(m_data), 32'hF0);
    chk("t4_valid", 32'(m_valid), 32'h1);
    chk("t4_overrun", 32'(m_ovr), 32'h1);
    chk("t4_l_overrun", 32'(l_ovr), 32'h1);
    consume();
    chk("t4_drained", 32'(m_valid), 32'h0);
    chk("t4_overrun_sticky", 32'(m_ovr), 32'h1);

    rst = 1'b1; tick(); rst = 1'b0;
    chk("t4_rst_overrun", 32'(m_ovr), 32'h0);

    // Continuous frames; consume and complete on the same edge
    push(8'hAA);
    push(8'hFF);
    send_frame(8'hAA, 0, 0, 0, 1'b0);
    send_frame(8'hFF, 0, 0, 0, 1'b1);
    chk("t5_m_data", 32'(m_data), 32'hFF);
    chk("t5_valid", 32'(m_valid), 32'h1);
    chk("t5_overrun", 32'(m_ovr), 32'h0);
    chk("t5_bit_cnt", 32'(m_cnt), 32'h0);
    consume();

    // Flush mid-frame (flush has priority over load)
    for (int i = 0; i < 4; i++) begin
      load = 1'b1; data_in = 1'b1; tick();
    end
    chk("t6_pre_flush_cnt", 32'(m_cnt), 32'h4);
    flush = 1'b1; load = 1'b1; data_in = 1'b1; tick();
    flush = 1'b0; load = 1'b0;
    chk("t6_flush_cnt", 32'(m_cnt), 32'h0);
    chk("t6_no_word", 32'(m_valid), 32'h0);
    push(8'h3C);
    send_frame(8'h3C, 0, 0, 0, 1'b0);
    chk("t6_m_data", 32'(m_data), 32'h3C);
    chk("t6_l_data", 32'(l_data), 32'h3C);

    // Flush on a would-be completion edge with the holder full
    for (int i = 0; i < W - 1; i++) begin
      load = 1'b1; data_in = 1'b1; tick();
    end
    flush = 1'b1; load = 1'b1; data_in = 1'b1; tick();
    flush = 1'b0; load = 1'b0;
    chk("t6_flush_last_cnt", 32'(m_cnt), 32'h0);
    chk("t6_holder_kept", 32'(m_data), 32'h3C);
    chk("t6_holder_valid", 32'(m_valid), 32'h1);
    chk("t6_no_overrun", 32'(m_ovr), 32'h0);
    consume();

    // Reset mid-frame while a word is held
    send_frame(8'hAA, 0, 0, 0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      load = 1'b1; data_in = 1'b1; tick();
    end
    rst = 1'b1; tick(); rst = 1'b0; load = 1'b0;
    chk("t6_rst_data", 32'(m_data), 32'h0);
    chk("t6_rst_valid", 32'(m_valid), 32'h0);
    chk("t6_rst_overrun", 32'(m_ovr), 32'h0);
    chk("t6_rst_bit_cnt", 32'(m_cnt), 32'h0);
    tick();

    chk("m_queue_empty", 32'(q_m.size()), 32'h0);
    chk("l_queue_empty", 32'(q_l.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
